// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the selectable pipeline register.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: sel_width() sizes the select bus; stage_t is one pipeline stage record.
package mux_pipe_pkg;

    // Upper bound on the data field carried by a stage record. Instances use
    // the low WIDTH bits; the rest are tied off and never reach a flop.
    localparam int STAGE_DATA_MAX = 64;

    // Select width: at least one bit even for the smallest legal NUM_IN.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                      valid;
        logic                      parity;  // only carried when PARITY_EN is defined
        logic [STAGE_DATA_MAX-1:0] data;
    } stage_t;

endpackage

// File: rtl/mux_pipe_reg_if.sv
// Bus bundle for mux_pipe_reg: select/data/enable inputs and registered outputs.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take q whenever q_valid=1 and en=1.
// Signals: en, sclr, sel, d, in_valid (master -> slave); q, q_valid, sel_err
// (slave -> master). Optional macro PARITY_EN adds q_par (slave -> master).
interface mux_pipe_reg_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
);
    import mux_pipe_pkg::*;

    localparam int SEL_W = sel_width(NUM_IN);

    logic                    en;
    logic                    sclr;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] d;
    logic                    in_valid;
    logic [WIDTH-1:0]        q;
    logic                    q_valid;
    logic                    sel_err;
`ifdef PARITY_EN
    logic                    q_par;

    modport master (
        output en, sclr, sel, d, in_valid,
        input  q, q_valid, sel_err, q_par
    );
    modport slave (
        input  en, sclr, sel, d, in_valid,
        output q, q_valid, sel_err, q_par
    );
`else
    modport master (
        output en, sclr, sel, d, in_valid,
        input  q, q_valid, sel_err
    );
    modport slave (
        input  en, sclr, sel, d, in_valid,
        output q, q_valid, sel_err
    );
`endif

endinterface

// File: rtl/mux_pipe_stage.sv
// One register stage of the select pipeline: holds valid, data and (optionally) parity.
// Latency: 1 enabled clk edge.
// Backpressure: none; en=0 holds the stage, sclr clears it and wins over en.
// Ports: clk, rst (async active-low), en, sclr, din/dout stage records.
// Macro PARITY_EN: when undefined no parity flop exists and dout.parity is 0.
module mux_pipe_stage
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   sclr,
    input  stage_t din,
    output stage_t dout
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (sclr) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (en) begin
            valid_r <= din.valid;
            data_r  <= din.data[WIDTH-1:0];
        end
    end

    assign dout.valid = valid_r;
    assign dout.data  = STAGE_DATA_MAX'(data_r);

`ifdef PARITY_EN
    logic par_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_r <= 1'b0;
        end else if (sclr) begin
            par_r <= 1'b0;
        end else if (en) begin
            par_r <= din.parity;
        end
    end

    assign dout.parity = par_r;

    // Upper data bits of the record are never registered.
    logic unused_din;
    assign unused_din = ^din.data;
`else
    assign dout.parity = 1'b0;

    // Parity and upper data bits of the record are never registered.
    logic unused_din;
    assign unused_din = ^{din.parity, din.data};
`endif

endmodule

// File: rtl/mux_pipe_reg.sv
// N-way selectable data register followed by a DEPTH-stage pipeline with valid tracking.
// Latency: DEPTH enabled clk edges from sample to q.
// Backpressure: none; en=0 freezes all stages and sel_err, sclr clears them (sclr wins).
// Ports: clk, rst (async active-low), bus (mux_pipe_reg_if.slave: en, sclr, sel, d,
// in_valid -> q, q_valid, sel_err). Macro PARITY_EN adds bus.q_par (even parity of q).
// WIDTH/NUM_IN must match the parameters of the connected interface instance.
module mux_pipe_reg
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 1
) (
    input  logic            clk,
    input  logic            rst,
    mux_pipe_reg_if.slave   bus
);

    localparam int SEL_W = sel_width(NUM_IN);

    stage_t [DEPTH:0] chain;   // chain[0] = select output, chain[DEPTH] = q side
    stage_t           s0;
    logic             sel_hit;
    logic [WIDTH-1:0] pick;
    logic             sel_err_r;

    // Select by equality against every legal index instead of indexing with sel:
    // an out-of-range or unknown sel matches nothing, so it yields data 0 /
    // valid 0 and flags sel_err without any separate range or X test.
    always_comb begin
        pick    = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_hit = 1'b1;
                pick    = bus.d[i*WIDTH +: WIDTH];
            end
        end
        s0       = '0;
        s0.data  = STAGE_DATA_MAX'(pick);
        s0.valid = sel_hit & bus.in_valid;
`ifdef PARITY_EN
        s0.parity = ^pick;
`endif
    end

    assign chain[0] = s0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        mux_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en   (bus.en),
            .sclr (bus.sclr),
            .din  (chain[k]),
            .dout (chain[k+1])
        );
    end

    // Reports the most recently accepted sample only, so it tracks en/sclr
    // exactly like stage 0 rather than travelling down the pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_err_r <= 1'b0;
        end else if (bus.sclr) begin
            sel_err_r <= 1'b0;
        end else if (bus.en) begin
            sel_err_r <= ~sel_hit & bus.in_valid;
        end
    end

    assign bus.q       = chain[DEPTH].data[WIDTH-1:0];
    assign bus.q_valid = chain[DEPTH].valid;
    assign bus.sel_err = sel_err_r;
`ifdef PARITY_EN
    assign bus.q_par   = chain[DEPTH].parity;
`endif

    // The last record's zero-extended data bits (and parity when unused) have no reader.
    logic unused_tail;
    assign unused_tail = ^chain[DEPTH];

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Self-checking bench for mux_pipe_reg (WIDTH=8, NUM_IN=3, DEPTH=2).
// A history-of-accepted-samples model predicts q/q_valid/sel_err every cycle;
// directed literal expectations pin the model at the notable points.
module tb_mux_pipe_reg;

    localparam int W = 8;
    localparam int N = 3;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mux_pipe_reg_if #(.WIDTH(W), .NUM_IN(N)) bus ();

    mux_pipe_reg #(.WIDTH(W), .NUM_IN(N), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PARITY_EN
    mux_pipe_reg_if #(.WIDTH(W), .NUM_IN(N)) bus1 ();

    mux_pipe_reg #(.WIDTH(W), .NUM_IN(N), .DEPTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // q is the sample accepted DEPTH enabled edges ago; nothing accepted since
    // reset/clear means q reads as zero.
    typedef struct {
        logic [W-1:0] data;
        logic         valid;
    } samp_t;

    samp_t hist[$];
    logic  m_err;

    function automatic samp_t take_sample();
        samp_t            r;
        logic [N*W-1:0]   dv;
        int               si;
        dv = bus.d;
        si = int'(bus.sel);
        r.data  = '0;
        r.valid = 1'b0;
        if (si < N) begin
            r.data  = dv[si*W +: W];
            r.valid = bus.in_valid;
        end
        return r;
    endfunction

    function automatic samp_t expect_out();
        samp_t r;
        r.data  = '0;
        r.valid = 1'b0;
        if (hist.size() >= D) r = hist[hist.size()-D];
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
            m_err <= 1'b0;
        end else if (bus.sclr) begin
            hist.delete();
            m_err <= 1'b0;
        end else if (bus.en) begin
            m_err <= (int'(bus.sel) >= N) && bus.in_valid;
            hist.push_back(take_sample());
            if (hist.size() > D) void'(hist.pop_front());
        end
    end

    // Compare against the model every cycle, half a period after the edge.
    always @(negedge clk) begin
        chk("model_q",       32'(bus.q),       32'(expect_out().data));
        chk("model_q_valid", 32'(bus.q_valid), 32'(expect_out().valid));
        chk("model_sel_err", 32'(bus.sel_err), 32'(m_err));
`ifdef PARITY_EN
        chk("model_q_par",   32'(bus.q_par),   32'(^expect_out().data));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #5;
    endtask

    task automatic set(input logic e, input logic s, input logic [1:0] sl,
                       input logic [N*W-1:0] dd, input logic iv);
        bus.en       = e;
        bus.sclr     = s;
        bus.sel      = sl;
        bus.d        = dd;
        bus.in_valid = iv;
    endtask

    logic [N*W-1:0] dd0;
    logic [N*W-1:0] dd1;
    logic [N*W-1:0] dd2;

    initial begin
        dd0 = {8'h33, 8'h22, 8'h11};
        dd1 = {8'h99, 8'h88, 8'h77};
        dd2 = {8'h33, 8'h22, 8'hA5};
        set(1'b0, 1'b0, 2'd0, '0, 1'b0);
`ifdef PARITY_EN
        bus1.en = 1'b0; bus1.sclr = 1'b0; bus1.sel = '0; bus1.d = '0; bus1.in_valid = 1'b0;
`endif
        #1 rst = 1'b0;
        #2;
        chk("reset_q",       32'(bus.q),       32'h0);
        chk("reset_q_valid", 32'(bus.q_valid), 32'h0);
        chk("reset_sel_err", 32'(bus.sel_err), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Latency: sample shows after the 2nd edge, not the 1st.
        set(1'b1, 1'b0, 2'd2, dd0, 1'b1);
        cyc();
        chk("lat_first_edge_q_valid", 32'(bus.q_valid), 32'h0);
        cyc();
        chk("lat_q",       32'(bus.q),       32'h33);
        chk("lat_q_valid", 32'(bus.q_valid), 32'h1);

        // Hold with en=0 while inputs change, then resume shifting.
        set(1'b1, 1'b0, 2'd0, dd0, 1'b1);
        cyc();
        cyc();
        chk("load_q", 32'(bus.q), 32'h11);
        set(1'b0, 1'b0, 2'd1, dd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_q",       32'(bus.q),       32'h11);
            chk("hold_q_valid", 32'(bus.q_valid), 32'h1);
        end
        set(1'b1, 1'b0, 2'd1, dd0, 1'b1);
        cyc();
        chk("resume_q0", 32'(bus.q), 32'h11);
        cyc();
        chk("resume_q1", 32'(bus.q), 32'h22);

        // Data advances with in_valid=0; valid travels with it.
        set(1'b1, 1'b0, 2'd2, dd0, 1'b0);
        cyc();
        cyc();
        chk("novalid_q",       32'(bus.q),       32'h33);
        chk("novalid_q_valid", 32'(bus.q_valid), 32'h0);

        // Out-of-range select.
        set(1'b1, 1'b0, 2'd3, dd0, 1'b1);
        cyc();
        chk("oor_sel_err", 32'(bus.sel_err), 32'h1);
        set(1'b1, 1'b0, 2'd0, dd0, 1'b0);
        cyc();
        chk("oor_q",       32'(bus.q),       32'h0);
        chk("oor_q_valid", 32'(bus.q_valid), 32'h0);
        chk("oor_cleared", 32'(bus.sel_err), 32'h0);
        set(1'b1, 1'b0, 2'd3, dd0, 1'b1);
        cyc();
        set(1'b0, 1'b0, 2'd0, dd0, 1'b1);
        cyc();
        chk("oor_hold", 32'(bus.sel_err), 32'h1);
        set(1'b1, 1'b0, 2'd0, dd0, 1'b1);
        cyc();
        chk("oor_legal_clear", 32'(bus.sel_err), 32'h0);

        // Synchronous clear wins over en, and also acts with en=0.
        set(1'b1, 1'b0, 2'd1, dd0, 1'b1);
        cyc();
        cyc();
        set(1'b1, 1'b0, 2'd3, dd0, 1'b1);
        cyc();
        chk("pre_sclr_q",   32'(bus.q),       32'h22);
        chk("pre_sclr_err", 32'(bus.sel_err), 32'h1);
        set(1'b1, 1'b1, 2'd1, dd0, 1'b1);
        cyc();
        chk("sclr_q",       32'(bus.q),       32'h0);
        chk("sclr_q_valid", 32'(bus.q_valid), 32'h0);
        chk("sclr_err",     32'(bus.sel_err), 32'h0);
        set(1'b1, 1'b0, 2'd1, dd0, 1'b1);
        cyc();
        cyc();
        set(1'b0, 1'b1, 2'd1, dd0, 1'b1);
        cyc();
        chk("sclr_noen_q_valid", 32'(bus.q_valid), 32'h0);
        set(1'b1, 1'b0, 2'd1, dd0, 1'b1);
        cyc();
        chk("after_sclr_q0", 32'(bus.q_valid), 32'h0);
        cyc();
        chk("after_sclr_q1", 32'(bus.q), 32'h22);

        // Asynchronous reset mid-cycle with a live pipe and sel_err set.
        set(1'b1, 1'b0, 2'd0, dd2, 1'b1);
        cyc();
        set(1'b1, 1'b0, 2'd3, dd2, 1'b1);
        cyc();
        chk("pre_rst_q",   32'(bus.q),       32'hA5);
        chk("pre_rst_qv",  32'(bus.q_valid), 32'h1);
        chk("pre_rst_err", 32'(bus.sel_err), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst_q",       32'(bus.q),       32'h0);
        chk("arst_q_valid", 32'(bus.q_valid), 32'h0);
        chk("arst_sel_err", 32'(bus.sel_err), 32'h0);
        set(1'b0, 1'b0, 2'd0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

`ifdef PARITY_EN
        // Parity on a single-stage instance.
        bus1.en = 1'b1; bus1.sel = 2'd0; bus1.in_valid = 1'b1;
        bus1.d = {8'h00, 8'h00, 8'h07};
        cyc();
        chk("par_q_07", 32'(bus1.q),     32'h07);
        chk("par_07",   32'(bus1.q_par), 32'h1);
        bus1.d = {8'h00, 8'h00, 8'h03};
        cyc();
        chk("par_03",   32'(bus1.q_par), 32'h0);
        bus1.en = 1'b0;
`endif

        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
